// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector
// and any neighbouring status counters.
package seq_det_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_t;

   // Increment that sticks at max_value; callers size the result back down.
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input logic [31:0] max_value);
      return (value >= max_value) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/seq_det_window.sv
// Serial shift window with fill tracking and a length-masked pattern compare.
// hit is combinational and reflects the window as it will be after this edge.
module seq_det_window
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear_i,
   input  logic               shift_en_i,
   input  logic               din_i,
   input  logic [MAX_LEN-1:0] pattern_i,
   input  logic [LEN_W-1:0]   len_i,
   input  logic               overlap_i,
   output logic               hit_o
);

   logic [MAX_LEN-1:0] window_q;
   logic [MAX_LEN-1:0] window_d;
   logic [LEN_W-1:0]   fill_q;
   logic [LEN_W-1:0]   fill_d;
   logic [MAX_LEN-1:0] len_mask;

   // Only the low len bits take part in the compare.
   generate
      for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
         assign len_mask[gi] = (len_i > LEN_W'(gi));
      end
   endgenerate

   assign window_d = {window_q[MAX_LEN-2:0], din_i};
   assign fill_d   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

   assign hit_o = shift_en_i
                  && (fill_d >= len_i)
                  && (((window_d ^ pattern_i) & len_mask) == '0);

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         window_q <= '0;
         fill_q   <= '0;
      end else if (shift_en_i) begin
         window_q <= window_d;
         // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
         fill_q   <= (hit_o && !overlap_i) ? '0 : fill_d;
      end
   end

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector: config FSM, registered match
// pulse, saturating match counter and illegal-config error pulse.
module seq_det_prog
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN) + 1,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               din,
   input  logic               din_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   output logic               match,
   output logic [CNT_W-1:0]   match_count,
   output logic               armed,
   output logic               cfg_err
);

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   seq_state_t         state_q;
   logic [MAX_LEN-1:0] pattern_q;
   logic [LEN_W-1:0]   len_q;
   logic               overlap_q;
   logic               match_q;
   logic [CNT_W-1:0]   count_q;
   logic               cfg_err_q;

   logic cfg_legal;
   logic shift_en;
   logic clear_win;
   logic hit;

   assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
   // A config strobe takes precedence over a data bit arriving in the same cycle.
   assign shift_en  = (state_q == RUN) && din_valid && !cfg_load;
   assign clear_win = cfg_load && cfg_legal;

   seq_det_window #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_window (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (clear_win),
      .shift_en_i (shift_en),
      .din_i      (din),
      .pattern_i  (pattern_q),
      .len_i      (len_q),
      .overlap_i  (overlap_q),
      .hit_o      (hit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pattern_q <= '0;
         len_q     <= '0;
         overlap_q <= 1'b0;
         match_q   <= 1'b0;
         count_q   <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         match_q   <= 1'b0;
         cfg_err_q <= 1'b0;
         if (cfg_load) begin
            if (cfg_legal) begin
               state_q   <= RUN;
               pattern_q <= cfg_pattern;
               len_q     <= cfg_len;
               overlap_q <= cfg_overlap;
               count_q   <= '0;
            end else begin
               // Stored config is kept but unused until a legal reload.
               state_q   <= IDLE;
               cfg_err_q <= 1'b1;
            end
         end else if (state_q == RUN && hit) begin
            match_q <= 1'b1;
            count_q <= CNT_W'(sat_inc(32'(count_q), CNT_MAX));
         end
      end
   end

   assign match       = match_q;
   assign match_count = count_q;
   assign armed       = (state_q == RUN);
   assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog with a 2-bit counter so saturation is reachable.
module tb_seq_det_prog;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic               din;
   logic               din_valid;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               match;
   logic [CNT_W-1:0]   match_count;
   logic               armed;
   logic               cfg_err;

   int n_cmp = 0;
   int n_err = 0;

   seq_det_prog #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .match       (match),
      .match_count (match_count),
      .armed       (armed),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                      input logic ovl);
      cfg_load    = 1'b1;
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic send(input logic b);
      din       = b;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
   endtask

   task automatic gap(input logic b);
      din       = b;
      din_valid = 1'b0;
      tick();
   endtask

   logic [6:0] stream7;
   logic [6:0] exp_ovl;
   logic [6:0] exp_nov;
   logic [1:0] exp_sat [5];

   initial begin
      stream7 = 7'b1010101;   // sent MSB first
      exp_ovl = 7'b0010101;
      exp_nov = 7'b0010001;
      exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      reset = 1'b1; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      tick(); tick();
      chk("rst_armed", 32'(armed), 32'd0);
      chk("rst_count", 32'(match_count), 32'd0);
      chk("rst_match", 32'(match), 32'd0);
      chk("rst_cfgerr", 32'(cfg_err), 32'd0);
      reset = 1'b0;
      send(1'b1);
      chk("idle_nomatch", 32'(match), 32'd0);

      // Overlapping 101
      cfg(8'b101, 4'd3, 1'b1);
      chk("ovl_armed", 32'(armed), 32'd1);
      for (int i = 6; i >= 0; i--) begin
         send(stream7[i]);
         chk($sformatf("ovl_bit%0d", 7 - i), 32'(match), 32'(exp_ovl[i]));
      end
      gap(1'b1);
      chk("ovl_tail", 32'(match), 32'd0);
      chk("ovl_count", 32'(match_count), 32'd3);

      // Non-overlapping 101
      cfg(8'b101, 4'd3, 1'b0);
      chk("nov_count0", 32'(match_count), 32'd0);
      for (int i = 6; i >= 0; i--) begin
         send(stream7[i]);
         chk($sformatf("nov_bit%0d", 7 - i), 32'(match), 32'(exp_nov[i]));
      end
      chk("nov_count", 32'(match_count), 32'd2);

      // Illegal lengths
      cfg(8'b101, 4'd0, 1'b1);
      chk("ill0_err", 32'(cfg_err), 32'd1);
      chk("ill0_armed", 32'(armed), 32'd0);
      gap(1'b0);
      chk("ill0_errpulse", 32'(cfg_err), 32'd0);
      send(1'b1); chk("ill0_m1", 32'(match), 32'd0);
      send(1'b0); chk("ill0_m2", 32'(match), 32'd0);
      send(1'b1); chk("ill0_m3", 32'(match), 32'd0);
      cfg(8'b101, 4'd9, 1'b1);
      chk("ill9_err", 32'(cfg_err), 32'd1);
      chk("ill9_armed", 32'(armed), 32'd0);

      // Legal reload, 4-bit 1101
      cfg(8'b1101, 4'd4, 1'b1);
      chk("ld4_armed", 32'(armed), 32'd1);
      chk("ld4_err", 32'(cfg_err), 32'd0);
      send(1'b1); chk("ld4_m1", 32'(match), 32'd0);
      send(1'b1); chk("ld4_m2", 32'(match), 32'd0);
      send(1'b0); chk("ld4_m3", 32'(match), 32'd0);
      send(1'b1); chk("ld4_m4", 32'(match), 32'd1);
      chk("ld4_count", 32'(match_count), 32'd1);

      // Gapped 101, ignored bits are the complement of the real ones
      cfg(8'b101, 4'd3, 1'b1);
      for (int i = 6; i >= 2; i--) begin
         send(stream7[i]);
         chk($sformatf("gap_bit%0d", 7 - i), 32'(match), 32'(exp_ovl[i]));
         gap(~stream7[i]);
         chk($sformatf("gap_idle%0d", 7 - i), 32'(match), 32'd0);
      end
      chk("gap_count", 32'(match_count), 32'd2);

      // Saturation with len=1
      cfg(8'b1, 4'd1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         send(1'b1);
         chk($sformatf("sat_m%0d", i), 32'(match), 32'd1);
         chk($sformatf("sat_c%0d", i), 32'(match_count), 32'(exp_sat[i]));
      end
      send(1'b0);
      chk("sat_zero", 32'(match), 32'd0);
      chk("sat_hold", 32'(match_count), 32'd3);

      // cfg_load beats a simultaneous data bit
      din = 1'b1; din_valid = 1'b1;
      cfg(8'b1, 4'd1, 1'b1);
      din_valid = 1'b0;
      chk("cfgwin_match", 32'(match), 32'd0);
      chk("cfgwin_count", 32'(match_count), 32'd0);
      gap(1'b1);
      chk("cfgwin_idle", 32'(match_count), 32'd0);
      send(1'b1);
      chk("cfgwin_next", 32'(match), 32'd1);
      chk("cfgwin_cnt1", 32'(match_count), 32'd1);

      // Reset mid-stream
      cfg(8'b101, 4'd3, 1'b1);
      send(1'b1);
      send(1'b0);
      reset = 1'b1;
      tick();
      chk("rstm_armed", 32'(armed), 32'd0);
      chk("rstm_count", 32'(match_count), 32'd0);
      chk("rstm_match", 32'(match), 32'd0);
      reset = 1'b0;
      send(1'b1);
      chk("rstm_nomatch", 32'(match), 32'd0);
      chk("rstm_armed2", 32'(armed), 32'd0);

      // After re-arming, the pre-reset partial match must be gone
      cfg(8'b101, 4'd3, 1'b1);
      send(1'b1);
      chk("rearm_m1", 32'(match), 32'd0);
      send(1'b0);
      chk("rearm_m2", 32'(match), 32'd0);
      send(1'b1);
      chk("rearm_m3", 32'(match), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
